// File: rtl/post_dispatch_if.sv
// Post-FIFO pop port and per-channel response port of the post dispatcher.
// master: the dispatcher (pops the FIFO, drives responses).
// slave:  the environment (upstream FIFO plus response consumers).
interface post_dispatch_if #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned NUM_CH             = 8
);
  logic                            Fifo_Post_Read;
  logic [C_M_AXI_DATA_WIDTH+5:0]   Fifo_Post_Read_data;
  logic                            Fifo_Post_empty;
  logic [NUM_CH-1:0]               rsp_valid;
  logic [NUM_CH-1:0]               rsp_ready;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data;
  logic [2:0]                      rsp_seq;

  modport master (
    output Fifo_Post_Read,
    input  Fifo_Post_Read_data,
    input  Fifo_Post_empty,
    output rsp_valid,
    input  rsp_ready,
    output rsp_data,
    output rsp_seq
  );

  modport slave (
    input  Fifo_Post_Read,
    output Fifo_Post_Read_data,
    output Fifo_Post_empty,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_data,
    input  rsp_seq
  );
endinterface

// File: rtl/post_dispatch.sv
// Post dispatcher: pops entries {rdata, ServeNum, Seq} from an upstream FIFO
// and presents each one on the response channel selected by ServeNum.
// Entries whose ServeNum has no channel are dropped and counted.
// Optional feature, enabled by defining POST_DISPATCH_SEQ_CHECK_EN: per-channel
// Seq tracking that pulses seq_err on an out-of-order tag.
module post_dispatch #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned NUM_CH             = 8
) (
  input  logic            clk,
  input  logic            rstn,
  post_dispatch_if.master bus,
  output logic [7:0]      drop_cnt,
  output logic            seq_err,
  output logic [2:0]      err_ch,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

  state_e                        state_q, state_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] hold_data_q;
  logic [2:0]                    hold_ch_q;
  logic [2:0]                    hold_seq_q;
  logic [7:0]                    drop_cnt_q;

  logic [C_M_AXI_DATA_WIDTH-1:0] fetch_data;
  logic [2:0]                    fetch_ch;
  logic [2:0]                    fetch_seq;
  logic                          fetch_ok;
  logic [NUM_CH-1:0]             ch_sel;
  logic                          handshake;
  logic                          pop;

  // FIFO output is valid in the cycle after the pop, i.e. while in StFetch.
  assign fetch_seq  = bus.Fifo_Post_Read_data[2:0];
  assign fetch_ch   = bus.Fifo_Post_Read_data[5:3];
  assign fetch_data = bus.Fifo_Post_Read_data[C_M_AXI_DATA_WIDTH+5:6];
  assign fetch_ok   = 32'(fetch_ch) < NUM_CH;

  // Decode the held channel into a one-hot select (loop keeps NUM_CH < 8 in range).
  always_comb begin
    ch_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (32'(hold_ch_q) == i);
    end
  end

  // Only the selected channel's ready can complete the transfer.
  assign handshake = (state_q == StPresent) && |(ch_sel & bus.rsp_ready);

  // Next-state and pop strobe; a pop is only ever issued while the FIFO is non-empty.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.Fifo_Post_empty) begin
          pop     = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = fetch_ok ? StPresent : StIdle;
      end
      StPresent: begin
        if (handshake) begin
          if (!bus.Fifo_Post_empty) begin
            pop     = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register: loaded once per routable entry, stable through StPresent.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_data_q <= '0;
      hold_ch_q   <= '0;
      hold_seq_q  <= '0;
    end else if (state_q == StFetch && fetch_ok) begin
      hold_data_q <= fetch_data;
      hold_ch_q   <= fetch_ch;
      hold_seq_q  <= fetch_seq;
    end
  end

  // Saturating count of entries with no matching channel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt_q <= '0;
    end else if (state_q == StFetch && !fetch_ok && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Strobes are gated by rstn so they are low for the whole reset cycle.
  assign bus.Fifo_Post_Read = pop & rstn;
  assign bus.rsp_valid      = (state_q == StPresent && rstn) ? ch_sel : '0;
  assign bus.rsp_data       = hold_data_q;
  assign bus.rsp_seq        = hold_seq_q;
  assign drop_cnt           = drop_cnt_q;
  assign busy               = (state_q != StIdle);

`ifdef POST_DISPATCH_SEQ_CHECK_EN
  logic [2:0] exp_seq_q [NUM_CH];
  logic       seq_err_q;
  logic [2:0] err_ch_q;
  logic       seq_match;

  // Compare the fetched tag against the expected tag of its channel.
  always_comb begin
    seq_match = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(fetch_ch) == i) begin
        seq_match = (fetch_seq == exp_seq_q[i]);
      end
    end
  end

  // Expected-tag update: on a match Seq+1 equals expected+1, on a mismatch it
  // resyncs to the received tag, so both cases load Seq+1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        exp_seq_q[i] <= '0;
      end
      seq_err_q <= 1'b0;
      err_ch_q  <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (state_q == StFetch && fetch_ok) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (32'(fetch_ch) == i) begin
            exp_seq_q[i] <= fetch_seq + 3'd1;
          end
        end
        if (!seq_match) begin
          seq_err_q <= 1'b1;
          err_ch_q  <= fetch_ch;
        end
      end
    end
  end

  assign seq_err = seq_err_q;
  assign err_ch  = err_ch_q;
`else
  assign seq_err = 1'b0;
  assign err_ch  = 3'd0;
`endif

endmodule

// File: tb/tb_post_dispatch.sv
// Self-checking bench for post_dispatch: an 8-channel instance driven from a
// vector table and hand-written sequences, plus a 4-channel instance for drops.
module tb_post_dispatch;
  localparam int unsigned DW   = 64;
  localparam int unsigned NCH  = 8;
  localparam int unsigned NCH4 = 4;

  typedef logic [DW+5:0] entry_t;

  typedef struct {
    logic [2:0]    ch;
    logic [2:0]    seq;
    logic [DW-1:0] data;
    logic [7:0]    valid;
    logic          err;
  } vec_t;

  typedef struct {
    logic [7:0]    valid;
    logic [DW-1:0] data;
    logic [2:0]    seq;
    logic          err;
    logic [2:0]    ch;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  post_dispatch_if #(.C_M_AXI_DATA_WIDTH(DW), .NUM_CH(NCH))  bus ();
  post_dispatch_if #(.C_M_AXI_DATA_WIDTH(DW), .NUM_CH(NCH4)) bus4 ();

  logic [7:0] drop_cnt, drop_cnt4;
  logic       seq_err, seq_err4;
  logic [2:0] err_ch, err_ch4;
  logic       busy, busy4;

  post_dispatch #(.C_M_AXI_DATA_WIDTH(DW), .NUM_CH(NCH)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .drop_cnt(drop_cnt), .seq_err(seq_err), .err_ch(err_ch), .busy(busy)
  );

  post_dispatch #(.C_M_AXI_DATA_WIDTH(DW), .NUM_CH(NCH4)) u_dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4),
    .drop_cnt(drop_cnt4), .seq_err(seq_err4), .err_ch(err_ch4), .busy(busy4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Upstream FIFO models and scoreboard.
  entry_t fq[$];
  entry_t fq4[$];
  exp_t   sb[$];
  int     hs_times[$];
  logic   pop_pend  = 1'b0;
  logic   pop_pend4 = 1'b0;
  int     cyc = 0;
  int     viol = 0;
  int     dbl_err = 0;
  int     pops = 0;
  int     valid4_seen = 0;
  int     fall_cyc = 0;
  logic   prev_empty = 1'b1;
  logic   prev_err = 1'b0;
  logic   err_seen = 1'b0;
  logic [2:0] err_ch_seen = '0;
  logic   lat_arm = 1'b0;
  logic   hold_prev = 1'b0;
  logic [7:0]    pv_valid;
  logic [DW-1:0] pv_data;
  logic [2:0]    pv_seq;

  always @(posedge clk) cyc++;

  // FIFO data appears the cycle after a pop is seen.
  always @(posedge clk) begin
    #1;
    if (pop_pend && fq.size() > 0) bus.Fifo_Post_Read_data = fq.pop_front();
    bus.Fifo_Post_empty = (fq.size() == 0);
    if (pop_pend4 && fq4.size() > 0) bus4.Fifo_Post_Read_data = fq4.pop_front();
    bus4.Fifo_Post_empty = (fq4.size() == 0);
  end

  // Mid-cycle monitor: protocol checks and scoreboard compare on handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    logic hs;
    pop_pend  = bus.Fifo_Post_Read;
    pop_pend4 = bus4.Fifo_Post_Read;
    if (bus.Fifo_Post_Read && bus.Fifo_Post_empty) viol++;
    if (bus4.Fifo_Post_Read && bus4.Fifo_Post_empty) viol++;
    if (bus.Fifo_Post_Read) pops++;
    if (bus4.rsp_valid != '0) valid4_seen++;
    if (prev_empty && !bus.Fifo_Post_empty) fall_cyc = cyc;
    prev_empty = bus.Fifo_Post_empty;
    if (seq_err) begin
      if (prev_err) dbl_err++;
      err_seen    = 1'b1;
      err_ch_seen = err_ch;
    end
    prev_err = seq_err;
    hs = |(bus.rsp_valid & bus.rsp_ready);
    if (!rstn) begin
      hold_prev = 1'b0;
    end else begin
      if (lat_arm && bus.rsp_valid != '0) begin
        check("latency", 64'(cyc - fall_cyc), 64'd2);
        lat_arm = 1'b0;
      end
      if (hold_prev) begin
        check("hold_valid", bus.rsp_valid, pv_valid);
        check("hold_data", bus.rsp_data, pv_data);
        check("hold_seq", bus.rsp_seq, pv_seq);
      end
      if (hs) begin
        hs_times.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_rsp", bus.rsp_valid, 8'h00);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", bus.rsp_valid, e.valid);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_seq", bus.rsp_seq, e.seq);
          check("seq_err", err_seen, e.err);
          if (e.err) check("err_ch", err_ch_seen, e.ch);
        end
        err_seen = 1'b0;
      end
      hold_prev = (bus.rsp_valid != '0) && !hs;
      pv_valid  = bus.rsp_valid;
      pv_data   = bus.rsp_data;
      pv_seq    = bus.rsp_seq;
    end
  end

  task automatic push(input vec_t v);
    exp_t e;
    fq.push_back({v.data, v.ch, v.seq});
    e.valid = v.valid;
    e.data  = v.data;
    e.seq   = v.seq;
    e.ch    = v.ch;
`ifdef POST_DISPATCH_SEQ_CHECK_EN
    e.err = v.err;
`else
    e.err = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fq.size() == 0 && bus.Fifo_Post_empty && !busy && sb.size() == 0)
               && n < budget);
    check({name, "_drained"}, 64'(fq.size() == 0 && bus.Fifo_Post_empty && !busy
                                   && sb.size() == 0), 64'd1);
  endtask

  task automatic wait_idle4(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fq4.size() == 0 && bus4.Fifo_Post_empty && !busy4) && n < budget);
    check({name, "_drained"}, 64'(fq4.size() == 0 && bus4.Fifo_Post_empty && !busy4), 64'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid == '0 && n < budget);
    check(name, 64'(bus.rsp_valid != '0), 64'd1);
  endtask

  vec_t vt[12];
  vec_t vb;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    int n;
    vt[0]  = '{ch: 3'd2, seq: 3'd0, data: 64'hDEAD_BEEF_0000_0001, valid: 8'h04, err: 1'b0};
    vt[1]  = '{ch: 3'd1, seq: 3'd0, data: 64'h1111_0000_0000_0001, valid: 8'h02, err: 1'b0};
    vt[2]  = '{ch: 3'd1, seq: 3'd1, data: 64'h1111_0000_0000_0002, valid: 8'h02, err: 1'b0};
    vt[3]  = '{ch: 3'd1, seq: 3'd3, data: 64'h1111_0000_0000_0003, valid: 8'h02, err: 1'b1};
    vt[4]  = '{ch: 3'd1, seq: 3'd4, data: 64'h1111_0000_0000_0004, valid: 8'h02, err: 1'b0};
    vt[5]  = '{ch: 3'd7, seq: 3'd0, data: 64'h7777_0000_0000_0000, valid: 8'h80, err: 1'b0};
    vt[6]  = '{ch: 3'd7, seq: 3'd2, data: 64'h7777_0000_0000_0002, valid: 8'h80, err: 1'b1};
    vt[7]  = '{ch: 3'd7, seq: 3'd3, data: 64'h7777_0000_0000_0003, valid: 8'h80, err: 1'b0};
    vt[8]  = '{ch: 3'd6, seq: 3'd7, data: 64'h6666_0000_0000_0007, valid: 8'h40, err: 1'b1};
    vt[9]  = '{ch: 3'd6, seq: 3'd0, data: 64'h6666_0000_0000_0000, valid: 8'h40, err: 1'b0};
    vt[10] = '{ch: 3'd0, seq: 3'd0, data: 64'hFFFF_FFFF_FFFF_FFFF, valid: 8'h01, err: 1'b0};
    vt[11] = '{ch: 3'd3, seq: 3'd0, data: 64'h0000_0000_0000_0000, valid: 8'h08, err: 1'b0};

    rstn           = 1'b0;
    bus.rsp_ready  = '1;
    bus4.rsp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 8'h00);
    check("rst_fifo_read", bus.Fifo_Post_Read, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_seq_err", seq_err, 1'b0);
    check("rst_err_ch", err_ch, 3'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_rsp_seq", bus.rsp_seq, 3'd0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #2;
    rstn = 1'b1;

    // Single entries from idle, one at a time.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      lat_arm = 1'b1;
      push(vt[i]);
      wait_idle("vec", 50);
    end

    // Four entries queued together: one response every 2 cycles, in order.
    @(posedge clk); #2;
    hs_times.delete();
    vb = '{ch: 3'd0, seq: 3'd1, data: 64'hA000_0000_0000_0001, valid: 8'h01, err: 1'b0};
    push(vb);
    vb = '{ch: 3'd1, seq: 3'd5, data: 64'hA000_0000_0000_0002, valid: 8'h02, err: 1'b0};
    push(vb);
    vb = '{ch: 3'd0, seq: 3'd2, data: 64'hA000_0000_0000_0003, valid: 8'h01, err: 1'b0};
    push(vb);
    vb = '{ch: 3'd3, seq: 3'd1, data: 64'hA000_0000_0000_0004, valid: 8'h08, err: 1'b0};
    push(vb);
    wait_idle("batch", 60);
    check("batch_count", 64'(hs_times.size()), 64'd4);
    for (int i = 1; i < hs_times.size(); i++) begin
      check("batch_spacing", 64'(hs_times[i] - hs_times[i-1]), 64'd2);
    end

    // Channel 5 stalled while another channel is ready; a follower waits in the FIFO.
    @(posedge clk); #2;
    bus.rsp_ready = 8'h10;
    vb = '{ch: 3'd5, seq: 3'd0, data: 64'h5555_AAAA_5555_AAAA, valid: 8'h20, err: 1'b0};
    push(vb);
    vb = '{ch: 3'd4, seq: 3'd0, data: 64'h4444_0000_4444_0000, valid: 8'h10, err: 1'b0};
    push(vb);
    wait_valid("stall_valid", 20);
    p0 = pops;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("stall_onehot", bus.rsp_valid, 8'h20);
    end
    check("stall_no_pop", 64'(pops - p0), 64'd0);
    @(posedge clk); #2;
    bus.rsp_ready = '1;
    wait_idle("stall", 40);

    // Four-channel instance: ServeNum 6 is dropped, count saturates at 255.
    @(posedge clk); #2;
    fq4.push_back({64'h0, 3'd6, 3'd0});
    wait_idle4("drop1", 30);
    check("drop_cnt_1", drop_cnt4, 8'd1);
    @(posedge clk); #2;
    for (int i = 0; i < 299; i++) fq4.push_back({64'(i), 3'd6, 3'(i)});
    wait_idle4("drop300", 1000);
    check("drop_cnt_sat", drop_cnt4, 8'd255);
    check("drop_no_valid", 64'(valid4_seen), 64'd0);
    @(posedge clk); #2;
    fq4.push_back({64'hCAFE_F00D_1234_5678, 3'd3, 3'd0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus4.rsp_valid == '0 && n < 20);
    check("ch4_valid", bus4.rsp_valid, 4'b1000);
    check("ch4_data", bus4.rsp_data, 64'hCAFE_F00D_1234_5678);
    wait_idle4("ch4", 20);

    // Reset while presenting: response is discarded, counters cleared.
    @(posedge clk); #2;
    bus.rsp_ready = '0;
    vb = '{ch: 3'd3, seq: 3'd2, data: 64'h3333_3333_3333_3333, valid: 8'h08, err: 1'b0};
    push(vb);
    wait_valid("rst_present_valid", 20);
    @(posedge clk); #2;
    rstn = 1'b0;
    sb.delete();
    fq.delete();
    @(negedge clk);
    check("rst_mid_valid_now", bus.rsp_valid, 8'h00);
    @(posedge clk); #2;
    @(negedge clk);
    check("rst_mid_valid", bus.rsp_valid, 8'h00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_drop_cnt", drop_cnt4, 8'd0);
    check("rst_mid_rsp_data", bus.rsp_data, 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    bus.rsp_ready = '1;

    // After reset the per-channel expected tags start again from 0.
    @(posedge clk); #2;
    lat_arm = 1'b1;
    vb = '{ch: 3'd2, seq: 3'd0, data: 64'h0123_4567_89AB_CDEF, valid: 8'h04, err: 1'b0};
    push(vb);
    wait_idle("post_rst", 50);

    check("no_read_while_empty", 64'(viol), 64'd0);
    check("seq_err_one_cycle", 64'(dbl_err), 64'd0);
    check("main_drop_cnt", drop_cnt, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
